// File: rtl/line_mem_responder.sv
// Line-transfer main-memory model for the data cache.
// Serves 16-byte writebacks and fills with a programmable latency, a busy
// flag while a transfer is in flight and a one-cycle ready pulse on completion.
module line_mem_responder #(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w2,
  input  logic [31:0] w3,
  output logic [31:0] ow0,
  output logic [31:0] ow1,
  output logic [31:0] ow2,
  output logic [31:0] ow3,
  output logic        mem_busy,
  output logic        mem_ready
);

  localparam int AW = $clog2(DEPTH_LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic [127:0]   wr_line;
  logic           rd_pend;
  logic           commit, load;
  logic [127:0]   mem [DEPTH_LINES];

  // Address bits outside the line index are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{mem_wr_addr[31:AW+4], mem_wr_addr[3:0],
                         mem_rd_addr[31:AW+4], mem_rd_addr[3:0]};

  // Next-state and countdown logic; commit/load fire on the last count of WB/RD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (memory_write) begin
          state_nxt = WB;
          cnt_nxt   = CNT_LOAD;
        end else if (memory_read) begin
          state_nxt = RD;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WB: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_pend) begin
            state_nxt = RD;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          load      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags come straight from the state register.
  assign mem_busy  = (state == WB) || (state == RD);
  assign mem_ready = (state == DONE);

  // Control state register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request in IDLE so the cache may drop it after acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (memory_write) begin
        wr_idx  <= mem_wr_addr[AW+3:4];
        wr_line <= {w3, w2, w1, w0};
        rd_idx  <= mem_rd_addr[AW+3:4];
        rd_pend <= memory_read;
      end else if (memory_read) begin
        rd_idx  <= mem_rd_addr[AW+3:4];
        rd_pend <= 1'b0;
      end
    end
  end

  // Array write on the final WB edge; a reset on that edge drops the write.
  always_ff @(posedge clk) begin
    if (!RST && commit) begin
      mem[wr_idx] <= wr_line;
    end
  end

  // Fill words update only on the final RD edge and hold otherwise.
  always_ff @(posedge clk) begin
    if (RST) begin
      {ow3, ow2, ow1, ow0} <= '0;
    end else if (load) begin
      {ow3, ow2, ow1, ow0} <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for back-to-back minimum-latency fills.
module tb_line_mem_responder;

  logic        clk = 1'b0;
  logic        RST;
  logic        memory_read, memory_write;
  logic [31:0] mem_rd_addr, mem_wr_addr, w0, w1, w2, w3;
  logic [31:0] ow0, ow1, ow2, ow3;
  logic        mem_busy, mem_ready;

  logic        m_read, m_write;
  logic [31:0] m_ra, m_wa, m_w0, m_w1, m_w2, m_w3;
  logic [31:0] m_ow0, m_ow1, m_ow2, m_ow3;
  logic        m_busy, m_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  line_mem_responder #(.DEPTH_LINES(1024), .LATENCY(4)) dut (
    .clk(clk), .RST(RST),
    .memory_read(memory_read), .memory_write(memory_write),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .ow0(ow0), .ow1(ow1), .ow2(ow2), .ow3(ow3),
    .mem_busy(mem_busy), .mem_ready(mem_ready)
  );

  line_mem_responder #(.DEPTH_LINES(1024), .LATENCY(1)) dut_min (
    .clk(clk), .RST(RST),
    .memory_read(m_read), .memory_write(m_write),
    .mem_rd_addr(m_ra), .mem_wr_addr(m_wa),
    .w0(m_w0), .w1(m_w1), .w2(m_w2), .w3(m_w3),
    .ow0(m_ow0), .ow1(m_ow1), .ow2(m_ow2), .ow3(m_ow3),
    .mem_busy(m_busy), .mem_ready(m_ready)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one request, then measure edges to mem_ready, busy samples,
  // and whether mem_ready has dropped one edge later (DONE -> IDLE).
  task automatic do_req(input logic wr, input logic rd,
                        input logic [31:0] wa, input logic [31:0] ra,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        output int lat, output int busy_n, output logic rdy_after);
    memory_write = wr; memory_read = rd;
    mem_wr_addr = wa; mem_rd_addr = ra;
    w0 = d0; w1 = d1; w2 = d2; w3 = d3;
    step();
    memory_write = 1'b0; memory_read = 1'b0;
    mem_wr_addr = 32'hFFFF_FFF0; mem_rd_addr = 32'hFFFF_FFF0;
    w0 = 32'hBADBAD00; w1 = 32'hBADBAD01; w2 = 32'hBADBAD02; w3 = 32'hBADBAD03;
    busy_n = mem_busy ? 1 : 0;
    lat = 0;
    while (!mem_ready && lat < 60) begin
      step();
      lat++;
      busy_n += mem_busy ? 1 : 0;
    end
    step();
    rdy_after = mem_ready;
  endtask

  task automatic test_reset();
    total++;
    if ({ow0, ow1, ow2, ow3} !== 128'h0) begin
      bad++; $display("FAIL reset_ow: got %h want 0", {ow3, ow2, ow1, ow0});
    end
    total++;
    if ({mem_busy, mem_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: busy/ready got %b want 00", {mem_busy, mem_ready});
    end
    total++;
    if ({m_ow0, m_busy, m_ready} !== 34'h0) begin
      bad++; $display("FAIL reset_min: got ow0=%h busy=%b ready=%b want 0", m_ow0, m_busy, m_ready);
    end
  endtask

  task automatic test_wb_then_fill();
    int lat, bn; logic ra;
    do_req(1'b1, 1'b0, 32'h0000_0120, 32'h0, 32'h11111111, 32'h22222222,
           32'h33333333, 32'h44444444, lat, bn, ra);
    total++;
    if (lat !== 4 || bn !== 4) begin
      bad++; $display("FAIL wb_timing: lat=%0d busy=%0d want 4/4", lat, bn);
    end
    total++;
    if (ra !== 1'b0) begin
      bad++; $display("FAIL wb_pulse: ready after DONE got %b want 0", ra);
    end
    total++;
    if ({ow0, ow1, ow2, ow3} !== 128'h0) begin
      bad++; $display("FAIL wb_no_ow: got %h want 0", {ow0, ow1, ow2, ow3});
    end
    do_req(1'b0, 1'b1, 32'h0, 32'h0000_012C, 32'h0, 32'h0, 32'h0, 32'h0, lat, bn, ra);
    total++;
    if (lat !== 4 || bn !== 4) begin
      bad++; $display("FAIL fill_timing: lat=%0d busy=%0d want 4/4", lat, bn);
    end
    total++;
    if ({ow0, ow1, ow2, ow3} !== {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}) begin
      bad++; $display("FAIL fill_data: got %h want 11111111222222223333333344444444",
                      {ow0, ow1, ow2, ow3});
    end
  endtask

  task automatic test_combined();
    int lat, bn; logic ra;
    do_req(1'b1, 1'b1, 32'h40, 32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3, lat, bn, ra);
    total++;
    if (lat !== 8 || bn !== 8 || ra !== 1'b0) begin
      bad++; $display("FAIL combined_timing: lat=%0d busy=%0d ready_after=%b want 8/8/0", lat, bn, ra);
    end
    total++;
    if ({ow0, ow1, ow2, ow3} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
      bad++; $display("FAIL combined_data: got %h want A0..A3", {ow0, ow1, ow2, ow3});
    end
  endtask

  task automatic test_wrap();
    int lat, bn; logic ra;
    do_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, lat, bn, ra);
    do_req(1'b0, 1'b1, 32'h0, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h0, lat, bn, ra);
    total++;
    if (ow0 !== 32'hDEADBEEF || ow3 !== 32'h3) begin
      bad++; $display("FAIL wrap: ow0=%h ow3=%h want deadbeef/3", ow0, ow3);
    end
  endtask

  task automatic test_ignore_busy();
    int lat, bn, pulses, first; logic ra;
    do_req(1'b1, 1'b0, 32'h80, 32'h0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, lat, bn, ra);
    memory_read = 1'b1; mem_rd_addr = 32'h120;
    step();                                   // accept edge E0
    memory_read = 1'b0;
    step(); step();                           // E1, E2
    memory_write = 1'b1; mem_wr_addr = 32'h80;
    w0 = 32'hBAD0; w1 = 32'hBAD1; w2 = 32'hBAD2; w3 = 32'hBAD3;
    step();                                   // E3
    memory_write = 1'b0;
    pulses = 0; first = 0;
    for (int i = 4; i <= 12; i++) begin
      step();
      if (mem_ready) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    total++;
    if (pulses !== 1 || first !== 4) begin
      bad++; $display("FAIL busy_single_ready: pulses=%0d at E%0d want 1 at E4", pulses, first);
    end
    total++;
    if (ow0 !== 32'h11111111) begin
      bad++; $display("FAIL busy_fill_data: ow0=%h want 11111111", ow0);
    end
    do_req(1'b0, 1'b1, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, lat, bn, ra);
    total++;
    if ({ow0, ow1, ow2, ow3} !== {32'hC0, 32'hC1, 32'hC2, 32'hC3} || lat !== 4) begin
      bad++; $display("FAIL busy_line_kept: got %h lat=%0d want C0..C3 lat 4",
                      {ow0, ow1, ow2, ow3}, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn; logic ra;
    // Reset mid-RD: ow currently holds C0..C3 and must clear.
    memory_read = 1'b1; mem_rd_addr = 32'h120;
    step();
    memory_read = 1'b0;
    step(); step();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    total++;
    if ({ow0, ow1, ow2, ow3, mem_busy, mem_ready} !== 130'h0) begin
      bad++; $display("FAIL reset_mid_rd: ow=%h busy=%b ready=%b want all 0",
                      {ow0, ow1, ow2, ow3}, mem_busy, mem_ready);
    end
    // Immediate acceptance shows the FSM is back in IDLE.
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 32'h55, 32'h56, 32'h57, 32'h58, lat, bn, ra);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL reset_to_idle: lat=%0d want 4", lat);
    end
    // Reset during WB before commit discards the write.
    memory_write = 1'b1; mem_wr_addr = 32'h200;
    w0 = 32'h66; w1 = 32'h67; w2 = 32'h68; w3 = 32'h69;
    step();
    memory_write = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    do_req(1'b0, 1'b1, 32'h0, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0, lat, bn, ra);
    total++;
    if ({ow0, ow1, ow2, ow3} !== {32'h55, 32'h56, 32'h57, 32'h58}) begin
      bad++; $display("FAIL reset_wb_discard: got %h want 55..58", {ow0, ow1, ow2, ow3});
    end
  endtask

  task automatic test_min_latency();
    int pos[$];
    int both;
    m_write = 1'b1; m_wa = 32'h30;
    m_w0 = 32'h7000; m_w1 = 32'h7001; m_w2 = 32'h7002; m_w3 = 32'h7003;
    step();
    m_write = 1'b0;
    step(); step();                           // WB commit -> DONE -> IDLE
    m_read = 1'b1; m_ra = 32'h30;
    both = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (m_ready) pos.push_back(i);
      if (m_ready && m_busy) both++;
    end
    m_read = 1'b0;
    total++;
    if (pos.size() !== 4 || both !== 0) begin
      bad++; $display("FAIL min_pulse_count: pulses=%0d busy_in_done=%0d want 4/0", pos.size(), both);
    end
    for (int k = 0; k < pos.size() && k < 4; k++) begin
      total++;
      if (pos[k] !== 2 + 3 * k) begin
        bad++; $display("FAIL min_period: pulse %0d at edge %0d want %0d", k, pos[k], 2 + 3 * k);
      end
    end
    total++;
    if ({m_ow0, m_ow3} !== {32'h7000, 32'h7003}) begin
      bad++; $display("FAIL min_data: ow0=%h ow3=%h want 7000/7003", m_ow0, m_ow3);
    end
  endtask

  initial begin
    RST = 1'b1;
    memory_read = 1'b0; memory_write = 1'b0;
    mem_rd_addr = '0; mem_wr_addr = '0; w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    m_read = 1'b0; m_write = 1'b0;
    m_ra = '0; m_wa = '0; m_w0 = '0; m_w1 = '0; m_w2 = '0; m_w3 = '0;
    step(); step(); step();
    RST = 1'b0;
    step();
    test_reset();
    test_wb_then_fill();
    test_combined();
    test_wrap();
    test_ignore_busy();
    test_reset_mid();
    test_min_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Multi-cycle main-memory responder for the data cache's line-transfer interface. Serves 4-word (16-byte) line fills and dirty-line writebacks issued by the data cache (memory_read / memory_write, mem_rd_addr / mem_wr_addr, w0..w3 out of the cache, ow0..ow3 into it). It adds a programmable access latency and a completion handshake (mem_ready / mem_busy), so the cache FSM can be exercised against realistic memory stalls instead of a zero-latency array.

## Interface
- DEPTH_LINES, 1024: number of 128-bit lines stored; power of two, at least 2.
- LATENCY, 4: cycles per line transfer (writeback or fill); integer, at least 1.
- clk  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- memory_read  in  1  line-fill request; sampled only in IDLE.
- memory_write  in  1  line-writeback request; sampled only in IDLE.
- mem_rd_addr  in  32  fill byte address; bits [3:0] ignored.
- mem_wr_addr  in  32  writeback byte address; bits [3:0] ignored.
- w0, w1, w2, w3  in  32 each  writeback words; w0 is the lowest address in the line.
- ow0, ow1, ow2, ow3  out  32 each  fill words (registered); ow0 is the lowest address in the line.
- mem_busy  out  1  high while a transfer is in progress (WB or RD state).
- mem_ready  out  1  one-cycle completion pulse (DONE state).

## Operation
- Line index = addr[log2(DEPTH_LINES)+3 : 4]. Upper address bits are ignored, so addresses wrap modulo DEPTH_LINES lines.
- States: IDLE, WB, RD, DONE.
- IDLE, memory_write=1: latch mem_wr_addr, w0..w3, mem_rd_addr and memory_read into internal registers. Go to WB with cnt = LATENCY-1.
- IDLE, only memory_read=1: latch mem_rd_addr. Go to RD with cnt = LATENCY-1.
- IDLE, no request: stay in IDLE.
- WB: while cnt≠0, decrement cnt. At cnt=0, write the latched words into the array.
  - If the latched read flag is set, go to RD with cnt = LATENCY-1.
  - Otherwise go to DONE.
- RD: while cnt≠0, decrement cnt. At cnt=0, load the array line into ow0..ow3 and go to DONE.
- DONE: mem_ready=1 for exactly one cycle, then go to IDLE unconditionally. Requests present during DONE are not accepted.
- A request with both flags set is always serviced writeback first, then fill, with a single mem_ready at the end.
  - If both addresses index the same line, the fill returns the just-written data.
- Request inputs are ignored outside IDLE. The cache may drop or change them after the accepting edge.
- ow0..ow3 hold their value until the next fill completes. A writeback alone does not change them.
- Reset value of every output: mem_busy=0, mem_ready=0, ow0..ow3=0.
- Reset also forces state to IDLE and cnt to 0. Array contents are not cleared.
- Reset during WB before the commit edge: the write is discarded.
- Reset during RD: ow is not updated.

## Timing
- E0 is the rising edge at which a request is sampled in IDLE.
- Fill only: mem_busy is high from E0 to E_LATENCY. At E_LATENCY, ow is valid and mem_ready is high for the cycle that follows. Round trip is LATENCY cycles.
- Writeback only: the array commits at E_LATENCY. mem_ready is high for the cycle after E_LATENCY.
- Writeback plus fill: the commit happens at E_LATENCY; ow is valid and mem_ready is high after E_2·LATENCY.
- The earliest next acceptance is the edge that ends the DONE cycle plus one (IDLE must be occupied for one edge).
- mem_busy and mem_ready are decoded from the state register only. No combinational path runs from any input to any output.
- LATENCY=1: WB and RD each last a single cycle, and the above formulas still hold.
- Array read and write are synchronous. Read and write never happen on the same edge.

## Test plan
- **Reset:** assert RST for 2 cycles mid-RD (LATENCY=4). Required: ow0..ow3=0, mem_busy=0, mem_ready=0 on the next cycle; state IDLE.
- **Writeback then fill:** write line at 0x0000_0120 with w0..w3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444. After mem_ready, fill from 0x0000_012C. Required: ow0..ow3 equal those words; mem_ready exactly 4 cycles after each accept; mem_busy high 4 cycles.
- **Combined request:** memory_write at 0x40 (data 0xA0..0xA3) and memory_read at 0x40 on the same cycle. Required: one mem_ready, 8 cycles after accept; ow = 0xA0..0xA3.
- **Wrap-around:** DEPTH_LINES=1024. Write 0xDEADBEEF (w0) to 0x0000_4000. Fill from 0x0000_0000. Required: ow0=0xDEADBEEF.
- **Ignore while busy:** pulse memory_write at 0x80 two cycles after a fill request is accepted. Required: line 0x80 unchanged; a single mem_ready; next request accepted only after DONE→IDLE.
- **Minimum latency:** with LATENCY=1, run back-to-back fill requests held high continuously. Required: mem_ready pulses every 3 cycles (RD, DONE, IDLE); mem_busy never high in DONE.
